systolic_feeder: RTL and testbench

Operand staging and skew stage sitting directly upstream of the systolic array. Accepts an N×N left operand A and an N×N top operand B row by row over a valid/ready handshake, buffers them, then drives the array's left and top edges with diagonally skewed wavefronts. It then flushes zeros so that every partial product propagates through the array, and finally pulses `done`. It replaces direct unskewed edge feeding; the array's `matmul` enable is taken from this block's `feed_active`.

---
 rtl/systolic_feeder_pkg.sv | 29 ++
 rtl/systolic_feeder_operand_buffer.sv | 76 +++++++
 rtl/systolic_feeder.sv | 167 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array operand feeder: element width, FSM states
// and a lane unpack helper usable for any lane count and element width up to the maxima.
package systolic_feeder_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MaxLanes = 16;
    localparam int unsigned MaxDataW = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLoaded,
        StFeed,
        StFlush,
        StDone
    } state_e;

    // Callers zero-extend the packed row to the maximum width and truncate the result.
    function automatic logic [MaxDataW-1:0] lane_get(
        input logic [MaxLanes*MaxDataW-1:0] row,
        input int unsigned                  lane,
        input int unsigned                  width
    );
        logic [MaxLanes*MaxDataW-1:0] shifted;
        shifted = row >> (lane * width);
        return shifted[MaxDataW-1:0];
    endfunction

endpackage

// File: rtl/systolic_feeder_operand_buffer.sv
// N x N operand register file: row-wide write port and a combinational anti-diagonal read
// selected by phase t, either walking columns (left operand) or rows (top operand).
module operand_buffer
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DATA_W   = 8,
    parameter bit          ReadCols = 1'b1,
    localparam int unsigned IdxW    = $clog2(N),
    localparam int unsigned PhaseW  = $clog2(2 * N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [IdxW-1:0]     wr_row_i,
    input  logic [N*DATA_W-1:0] wr_data_i,
    input  logic [PhaseW-1:0]   rd_phase_i,
    output logic [N*DATA_W-1:0] rd_diag_o
);

    logic [DATA_W-1:0] mem_q [N][N];
    logic [DATA_W-1:0] mem_d [N][N];
    logic [MaxLanes*MaxDataW-1:0] wr_ext;

    always_comb begin
        wr_ext = '0;
        wr_ext[N*DATA_W-1:0] = wr_data_i;
    end

    always_comb begin
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                mem_d[r][c] = mem_q[r][c];
                if (wr_en_i && (wr_row_i == IdxW'(r))) begin
                    mem_d[r][c] = DATA_W'(lane_get(wr_ext, c, DATA_W));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    mem_q[r][c] <= mem_d[r][c];
                end
            end
        end
    end

    // Lane l at phase t sees element index t-l; lanes outside the wavefront read zero.
    always_comb begin
        int                diff;
        logic [IdxW-1:0]   idx;
        rd_diag_o = '0;
        for (int unsigned l = 0; l < N; l++) begin
            diff = int'(rd_phase_i) - int'(l);
            idx  = '0;
            if ((diff >= 0) && (diff < int'(N))) begin
                idx = diff[IdxW-1:0];
                if (ReadCols) begin
                    rd_diag_o[l*DATA_W +: DATA_W] = mem_q[l][idx];
                end else begin
                    rd_diag_o[l*DATA_W +: DATA_W] = mem_q[idx][l];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers N rows of A and B, then drives skewed wavefronts into the systolic array edges,
// flushes zeros for N cycles and pulses done. All outputs are registered.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = 4,
    parameter int unsigned DATA_W     = systolic_feeder_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ARRAY_SIZE*DATA_W-1:0] in_row_a,
    input  logic [ARRAY_SIZE*DATA_W-1:0] in_row_b,
    input  logic                         start,
    output logic [ARRAY_SIZE*DATA_W-1:0] left_out,
    output logic [ARRAY_SIZE*DATA_W-1:0] top_out,
    output logic                         feed_active,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned N      = ARRAY_SIZE;
    localparam int unsigned RowW   = $clog2(N);
    localparam int unsigned PhaseW = $clog2(2 * N);

    localparam logic [RowW-1:0]   RowLast   = RowW'(N - 1);
    localparam logic [PhaseW-1:0] FeedLast  = PhaseW'(2 * N - 2);
    localparam logic [PhaseW-1:0] FlushLast = PhaseW'(N - 1);

    state_e              state_q, state_d;
    logic [RowW-1:0]     row_q, row_d;
    logic [PhaseW-1:0]   phase_q, phase_d;
    logic                in_ready_q, in_ready_d;
    logic                feed_active_q, feed_active_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N*DATA_W-1:0] left_q, left_d;
    logic [N*DATA_W-1:0] top_q, top_d;
    logic [N*DATA_W-1:0] a_diag, b_diag;
    logic                load_fire;

    assign load_fire = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        phase_d = phase_q;
        unique case (state_q)
            StIdle, StLoad: begin
                if (load_fire) begin
                    if (row_q == RowLast) begin
                        state_d = StLoaded;
                    end else begin
                        state_d = StLoad;
                        row_d   = row_q + 1'b1;
                    end
                end
            end
            StLoaded: begin
                if (start) begin
                    state_d = StFeed;
                    phase_d = '0;
                end
            end
            StFeed: begin
                if (phase_q == FeedLast) begin
                    state_d = StFlush;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StFlush: begin
                if (phase_q == FlushLast) begin
                    state_d = StDone;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                row_d   = '0;
            end
            default: begin
                state_d = StIdle;
                row_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        in_ready_d    = (state_d == StIdle) || (state_d == StLoad);
        feed_active_d = (state_d == StFeed) || (state_d == StFlush);
        busy_d        = !((state_d == StIdle) || (state_d == StLoaded));
        done_d        = (state_d == StDone);
        left_d        = '0;
        top_d         = '0;
        if (state_d == StFeed) begin
            left_d = a_diag;
            top_d  = b_diag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            row_q         <= '0;
            phase_q       <= '0;
            in_ready_q    <= 1'b1;
            feed_active_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            left_q        <= '0;
            top_q         <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            phase_q       <= phase_d;
            in_ready_q    <= in_ready_d;
            feed_active_q <= feed_active_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            left_q        <= left_d;
            top_q         <= top_d;
        end
    end

    operand_buffer #(
        .N        (N),
        .DATA_W   (DATA_W),
        .ReadCols (1'b1)
    ) u_buf_a (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (load_fire),
        .wr_row_i   (row_q),
        .wr_data_i  (in_row_a),
        .rd_phase_i (phase_d),
        .rd_diag_o  (a_diag)
    );

    operand_buffer #(
        .N        (N),
        .DATA_W   (DATA_W),
        .ReadCols (1'b0)
    ) u_buf_b (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (load_fire),
        .wr_row_i   (row_q),
        .wr_data_i  (in_row_b),
        .rd_phase_i (phase_d),
        .rd_diag_o  (b_diag)
    );

    assign in_ready    = in_ready_q;
    assign feed_active = feed_active_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign left_out    = left_q;
    assign top_out     = top_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder at N=4: reset, backpressured load, skewed feed values,
// start-to-done timing, ignored start/valid, and asynchronous reset during FEED.
module tb_systolic_feeder;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_row_a;
    logic [N*W-1:0] in_row_b;
    logic           start;
    logic [N*W-1:0] left_out;
    logic [N*W-1:0] top_out;
    logic           feed_active;
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] a_m [N][N];
    logic [W-1:0] b_m [N][N];

    always #5 clk = ~clk;

    systolic_feeder #(
        .ARRAY_SIZE (N),
        .DATA_W     (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row_a    (in_row_a),
        .in_row_b    (in_row_b),
        .start       (start),
        .left_out    (left_out),
        .top_out     (top_out),
        .feed_active (feed_active),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] row_a(input int k);
        logic [N*W-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = a_m[k][c];
        return v;
    endfunction

    function automatic logic [N*W-1:0] row_b(input int k);
        logic [N*W-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = b_m[k][c];
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_left(input int t);
        logic [N*W-1:0] v = '0;
        for (int i = 0; i < N; i++) begin
            if ((t - i >= 0) && (t - i < N)) v[i*W +: W] = a_m[i][t-i];
        end
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_top(input int t);
        logic [N*W-1:0] v = '0;
        for (int j = 0; j < N; j++) begin
            if ((t - j >= 0) && (t - j < N)) v[j*W +: W] = b_m[t-j][j];
        end
        return v;
    endfunction

    task automatic load(input bit gaps, input bit start_at2);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_row_a = row_a(k);
            in_row_b = row_b(k);
            start    = start_at2 && (k == 2);
            step();
            start = 1'b0;
            check($sformatf("load_ready_row%0d", k), in_ready, k < N - 1);
            check($sformatf("load_busy_row%0d", k), busy, k < N - 1);
            if (gaps) begin
                in_valid = 1'b0;
                in_row_a = $urandom;
                in_row_b = $urandom;
                step();
                check($sformatf("gap_ready_row%0d", k), in_ready, k < N - 1);
            end
        end
        in_valid = 1'b0;
    endtask

    // Cycle 0 is the LOADED cycle with start high; cycles 1..13 are checked.
    task automatic run_op(input bit poke);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            int t = c - 1;
            check($sformatf("feed_active_c%0d", c), feed_active, c <= 11);
            check($sformatf("busy_c%0d", c), busy, c <= 12);
            check($sformatf("done_c%0d", c), done, c == 12);
            check($sformatf("in_ready_c%0d", c), in_ready, c == 13);
            check($sformatf("left_c%0d", c), left_out, (c <= 7) ? exp_left(t) : '0);
            check($sformatf("top_c%0d", c), top_out, (c <= 7) ? exp_top(t) : '0);
            if (c == 1) begin
                check("hand_left_t0", left_out, 32'h0);
                check("hand_top_t0", top_out, 32'h0000_0064);
            end
            if (c == 4) begin
                check("hand_left_t3", left_out, {8'd30, 8'd21, 8'd12, 8'd3});
                check("hand_top_t3", top_out, {8'd103, 8'd112, 8'd121, 8'd130});
            end
            if (c == 7) begin
                check("hand_left_t6", left_out, {8'd33, 24'd0});
                check("hand_top_t6", top_out, {8'd133, 24'd0});
            end
            start    = poke && (c == 3);
            in_valid = poke && (c == 5);
            in_row_a = $urandom;
            in_row_b = $urandom;
            if (c < 13) step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_left"}, left_out, '0);
        check({tag, "_top"}, top_out, '0);
        check({tag, "_feed_active"}, feed_active, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                a_m[i][k] = W'(10 * i + k);
                b_m[i][k] = W'(100 + 10 * i + k);
            end
        end

        rst      = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        in_row_a = '0;
        in_row_b = '0;
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'($urandom);
            start    = 1'($urandom);
            in_row_a = $urandom;
            in_row_b = $urandom;
            step();
            check_reset_outputs($sformatf("reset%0d", r));
        end
        in_valid = 1'b0;
        start    = 1'b0;
        rst      = 1'b1;
        step();
        check_reset_outputs("idle_after_reset");

        // Backpressured load with a start during row 2, then a 5th row offered in LOADED.
        load(1'b1, 1'b1);
        in_valid = 1'b1;
        in_row_a = {4{8'hEE}};
        in_row_b = {4{8'hDD}};
        step();
        check("loaded_ready", in_ready, 1'b0);
        check("loaded_busy", busy, 1'b0);
        check("loaded_feed_active", feed_active, 1'b0);
        in_valid = 1'b0;
        run_op(1'b1);

        // Reset asserted during FEED at t=3.
        load(1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre_reset_left_t3", left_out, exp_left(3));
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        rst = 1'b1;
        load(1'b0, 1'b0);
        run_op(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
